// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line parameters, frame shape.
// Imported by the transmitter and its bit timer.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and wraps; bit_end flags the last clock of a bit.
// No latency beyond the counter register; clear restarts the period on the next edge.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 transmitter draining a byte FIFO; START level appears on tx the edge after the pop cycle.
// Pops one byte per frame, only from IDLE; bytes arriving mid-frame wait in the FIFO.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int         BIT_CYCLES = CLK_FREQ / BAUD;
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_nxt;
    logic       r_tx;
    logic       w_tx_nxt;
    logic       w_pop;
    logic       w_bit_end;

    // FIFO read data is only valid while pop is high, so the byte is captured on the pop edge.
    assign w_pop = !rst && (r_state == ST_IDLE) && !fifo_empty;

    uart_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_pop),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // tx is registered, so each branch selects the level for the state being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = r_tx;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_pop) begin
                    w_shift_nxt   = fifo_rdata;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_START;
                    w_tx_nxt      = 1'b0;
                end
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign fifo_pop = w_pop;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != ST_IDLE);
    assign tx_done  = (r_state == ST_STOP) && w_bit_end;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a queue-based FIFO model feeds the DUT and a frame capturer checks
// each frame against the ideal 8N1 waveform for the byte the FIFO handed out.
module tb_uart_tx_drain;

    localparam int BC    = 10;
    localparam int FRAME = 10 * BC;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] push_buf [256];
    int         push_wr = 0;
    int         push_rd = 0;
    int         pop_count = 0;
    int         viol_empty = 0;
    int         viol_rst = 0;
    int         viol_double = 0;
    logic       prev_pop = 1'b0;
    logic       cap_tx [2*FRAME];

    uart_tx_drain #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: pop on a sampled pop request, then accept queued pushes.
    always @(posedge clk) begin
        if (fifo_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_count++;
        end
        while (push_rd != push_wr) begin
            fifo_q.push_back(push_buf[push_rd % 256]);
            push_rd++;
        end
        fifo_empty <= (fifo_q.size() == 0);
        if (fifo_q.size() > 0) fifo_rdata <= fifo_q[0];
        else                   fifo_rdata <= 8'h00;
    end

    always @(negedge clk) begin
        if (fifo_pop && fifo_empty) viol_empty++;
        if (fifo_pop && rst)        viol_rst++;
        if (fifo_pop && prev_pop)   viol_double++;
        prev_pop = fifo_pop;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        push_buf[push_wr % 256] = b;
        push_wr++;
    endtask

    // Ideal line level at cycle c of a frame carrying byte b.
    function automatic logic exp_level(input logic [7:0] b, input int c);
        int bit_no;
        bit_no = c / BC;
        if (bit_no == 0) return 1'b0;
        if (bit_no >= 9) return 1'b1;
        return b[bit_no-1];
    endfunction

    function automatic int level_errs(input logic [7:0] b, input int len);
        int e;
        e = 0;
        for (int c = 0; c < len && c < 2*FRAME; c++)
            if (cap_tx[c] !== exp_level(b, c)) e++;
        if (len != FRAME) e++;
        return e;
    endfunction

    // Called on a negedge; counts idle cycles, then records tx for every busy cycle.
    task automatic capture(output logic [7:0] data, output int len, output int done_cnt,
                           output int done_pos, output int idle, output bit ok);
        ok = 1'b1; idle = 0; len = 0; done_cnt = 0; done_pos = -1; data = 8'h00;
        while (!tx_busy && idle < 500) begin
            idle++;
            @(negedge clk);
        end
        if (!tx_busy) begin
            ok = 1'b0;
            return;
        end
        while (tx_busy && len < 2*FRAME) begin
            cap_tx[len] = tx;
            if (tx_done) begin
                done_cnt++;
                done_pos = len + 1;
            end
            len++;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) data[k] = cap_tx[(k+1)*BC + BC/2];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_tests++;
            if ({tx, fifo_pop, tx_busy, tx_done} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got tx/pop/busy/done=%b expected 1000", i, {tx, fifo_pop, tx_busy, tx_done});
            end
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({tx, fifo_pop, tx_busy, tx_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 1000", {tx, fifo_pop, tx_busy, tx_done});
        end
    endtask

    task automatic test_single();
        logic [7:0] d; int len, dc, dp, idle, pc0; bit ok;
        pc0 = pop_count;
        sync(); push(8'hA5); @(negedge clk);
        capture(d, len, dc, dp, idle, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: no frame after %0d idle cycles", idle); end
        n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", d); end
        n_tests++; if (len !== FRAME) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", len, FRAME); end
        n_tests++; if (dc !== 1 || dp !== FRAME) begin n_fail++; $display("FAIL single_done: got %0d pulses at %0d expected 1 at %0d", dc, dp, FRAME); end
        n_tests++; if (level_errs(8'hA5, len) !== 0) begin n_fail++; $display("FAIL single_levels: got %0d bad cycles expected 0", level_errs(8'hA5, len)); end
        n_tests++; if (pop_count - pc0 !== 1) begin n_fail++; $display("FAIL single_pops: got %0d expected 1", pop_count - pc0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4]; logic [7:0] d; int len, dc, dp, idle, pc0; bit ok;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55; exp[3] = 8'h3C;
        pc0 = pop_count;
        sync();
        for (int i = 0; i < 4; i++) push(exp[i]);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            capture(d, len, dc, dp, idle, ok);
            n_tests++; if (ok !== 1'b1 || d !== exp[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, d, exp[i]); end
            n_tests++; if (level_errs(exp[i], len) !== 0 || dc !== 1 || dp !== FRAME) begin n_fail++; $display("FAIL b2b_frame[%0d]: got len %0d done %0d@%0d expected %0d, 1@%0d", i, len, dc, dp, FRAME, FRAME); end
            if (i > 0) begin
                n_tests++; if (idle !== 1) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d idle cycles expected 1", i, idle); end
            end
        end
        n_tests++; if (pop_count - pc0 !== 4) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 4", pop_count - pc0); end
        n_tests++; if (fifo_q.size() !== 0) begin n_fail++; $display("FAIL b2b_fifo_empty: got %0d entries expected 0", fifo_q.size()); end
    endtask

    task automatic test_push_during_frame();
        logic [7:0] d1, d2; int l1, dc1, dp1, id1, l2, dc2, dp2, id2, pc0, pc_mid; bit ok1, ok2;
        pc0 = pop_count; pc_mid = 0;
        sync(); push(8'h12); @(negedge clk);
        fork
            capture(d1, l1, dc1, dp1, id1, ok1);
            begin
                repeat (35) @(posedge clk);
                #1;
                push(8'h81);
                pc_mid = pop_count;
            end
        join
        n_tests++; if (ok1 !== 1'b1 || d1 !== 8'h12 || level_errs(8'h12, l1) !== 0) begin n_fail++; $display("FAIL mid_push_first: got %h len %0d expected 12 len %0d", d1, l1, FRAME); end
        n_tests++; if (pop_count - pc0 !== 1 || pc_mid - pc0 !== 1) begin n_fail++; $display("FAIL mid_push_no_early_pop: got %0d pops expected 1", pop_count - pc0); end
        capture(d2, l2, dc2, dp2, id2, ok2);
        n_tests++; if (ok2 !== 1'b1 || d2 !== 8'h81) begin n_fail++; $display("FAIL mid_push_second: got %h expected 81", d2); end
        n_tests++; if (id2 !== 1 || level_errs(8'h81, l2) !== 0) begin n_fail++; $display("FAIL mid_push_gap: got gap %0d len %0d expected 1, %0d", id2, l2, FRAME); end
        n_tests++; if (dc1 !== 1 || dc2 !== 1 || dp1 !== FRAME || dp2 !== FRAME || id1 < 1) begin n_fail++; $display("FAIL mid_push_done: got %0d@%0d, %0d@%0d expected 1@%0d", dc1, dp1, dc2, dp2, FRAME); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d; int len, dc, dp, idle, pc0, w; bit ok;
        pc0 = pop_count;
        sync(); push(8'hF0); push(8'h33); @(negedge clk);
        w = 0;
        while (!tx_busy && w < 50) begin w++; @(negedge clk); end
        n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL abort_start: got busy %b expected 1", tx_busy); end
        repeat (43) @(negedge clk);
        n_tests++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL abort_bit3: got tx %b busy %b expected 0 1", tx, tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({tx, tx_busy, tx_done, fifo_pop} !== 4'b1000) begin n_fail++; $display("FAIL abort_state: got tx/busy/done/pop=%b expected 1000", {tx, tx_busy, tx_done, fifo_pop}); end
        n_tests++; if (fifo_q.size() !== 1) begin n_fail++; $display("FAIL abort_fifo: got %0d entries expected 1", fifo_q.size()); end
        rst = 1'b0;
        capture(d, len, dc, dp, idle, ok);
        n_tests++; if (ok !== 1'b1 || d !== 8'h33 || idle !== 1) begin n_fail++; $display("FAIL abort_next: got %h after %0d idle expected 33 after 1", d, idle); end
        n_tests++; if (level_errs(8'h33, len) !== 0 || dc !== 1 || dp !== FRAME) begin n_fail++; $display("FAIL abort_next_frame: got len %0d done %0d@%0d expected %0d 1@%0d", len, dc, dp, FRAME, FRAME); end
        n_tests++; if (pop_count - pc0 !== 2) begin n_fail++; $display("FAIL abort_pops: got %0d expected 2", pop_count - pc0); end
    endtask

    task automatic test_random();
        logic [7:0] model_q[$]; logic [7:0] b, d, e; int k, len, dc, dp, idle; bit ok;
        for (int r = 0; r < 5; r++) begin
            k = $urandom_range(1, 4);
            sync();
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                model_q.push_back(b);
                push(b);
            end
            @(negedge clk);
            for (int i = 0; i < k; i++) begin
                e = model_q.pop_front();
                capture(d, len, dc, dp, idle, ok);
                n_tests++; if (ok !== 1'b1 || d !== e) begin n_fail++; $display("FAIL rand_data r%0d[%0d]: got %h expected %h", r, i, d, e); end
                n_tests++; if (level_errs(e, len) !== 0 || dc !== 1 || dp !== FRAME || (i > 0 && idle !== 1)) begin n_fail++; $display("FAIL rand_frame r%0d[%0d]: got len %0d done %0d@%0d gap %0d", r, i, len, dc, dp, idle); end
            end
        end
    endtask

    task automatic test_pop_rules();
        repeat (3) @(negedge clk);
        n_tests++; if (viol_empty !== 0) begin n_fail++; $display("FAIL pop_while_empty: got %0d expected 0", viol_empty); end
        n_tests++; if (viol_rst !== 0) begin n_fail++; $display("FAIL pop_while_rst: got %0d expected 0", viol_rst); end
        n_tests++; if (viol_double !== 0) begin n_fail++; $display("FAIL pop_two_cycles: got %0d expected 0", viol_double); end
        n_tests++; if (pop_count !== push_wr) begin n_fail++; $display("FAIL pop_total: got %0d expected %0d", pop_count, push_wr); end
        n_tests++; if (fifo_q.size() !== 0 || {tx, tx_busy} !== 2'b10) begin n_fail++; $display("FAIL final_idle: got %0d entries tx/busy %b expected 0, 10", fifo_q.size(), {tx, tx_busy}); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_push_during_frame();
        test_reset_mid_frame();
        test_random();
        test_pop_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
